// File: rtl/wave_pkg.sv
// Shared defaults and FSM state encoding for the waveform writer and playback control.
package wave_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned OFF_W_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FINISH  = 2'd2
  } wave_state_e;

endpackage

// File: rtl/wave_wr_addr_gen.sv
// Write-address generator: latched base/limit, sample offset counter, base+offset
// adder and terminal-count compare for the waveform writer.
module wave_wr_addr_gen
  import wave_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned OFF_W  = OFF_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [OFF_W:0]    limit_i,
  input  logic              adv_i,
  output logic [OFF_W:0]    offset_o,
  output logic [OFF_W:0]    offset_inc_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              term_o
);

  localparam logic [OFF_W:0] MAX_LEN = {1'b1, {OFF_W{1'b0}}};

  logic [ADDR_W-1:0] base_q;
  logic [OFF_W:0]    limit_q;
  logic [OFF_W:0]    offset_q;
  logic [OFF_W:0]    limit_sat;

  // Requests above 2**OFF_W saturate so offset can never pass the region size.
  assign limit_sat = (limit_i > MAX_LEN) ? MAX_LEN : limit_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      limit_q  <= '0;
      offset_q <= '0;
    end else if (load_i) begin
      base_q   <= base_i;
      limit_q  <= limit_sat;
      offset_q <= '0;
    end else if (adv_i) begin
      offset_q <= offset_inc_o;
    end
  end

  assign offset_o     = offset_q;
  assign offset_inc_o = offset_q + 1'b1;
  assign addr_o       = base_q + ADDR_W'(offset_q);
  assign term_o       = (offset_inc_o == limit_q);

endmodule

// File: rtl/wave_writer.sv
// Waveform RAM write side: captures a valid/ready sample stream into a contiguous
// region from beg_addr and reports the stored length for playback programming.
module wave_writer
  import wave_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OFF_W  = OFF_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] beg_addr,
  input  logic [OFF_W:0]    max_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [OFF_W:0]    wave_len
);

  wave_state_e       state_q, state_d;
  logic              s_ready_q, s_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic [OFF_W:0]    wave_len_q, wave_len_d;

  logic              load, adv, accept, term;
  logic [OFF_W:0]    offset, offset_inc;
  logic [ADDR_W-1:0] wr_addr;

  wave_wr_addr_gen #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (reset_n),
    .load_i       (load),
    .base_i       (beg_addr),
    .limit_i      (max_len),
    .adv_i        (adv),
    .offset_o     (offset),
    .offset_inc_o (offset_inc),
    .addr_o       (wr_addr),
    .term_o       (term)
  );

  assign accept = s_valid & s_ready_q;

  always_comb begin
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    wave_len_d  = wave_len_q;
    load        = 1'b0;
    adv         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          load = 1'b1;
          if (max_len == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d   = ST_CAPTURE;
            s_ready_d = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr;
          mem_wdata_d = s_data;
          adv         = 1'b1;
          if (term || s_last) begin
            state_d   = ST_FINISH;
            s_ready_d = 1'b0;
          end
        end
        // A sample handshaken in the abort cycle is still written, so it is counted.
        if (abort) begin
          state_d    = ST_IDLE;
          s_ready_d  = 1'b0;
          wave_len_d = accept ? offset_inc : offset;
        end
      end
      ST_FINISH: begin
        state_d    = ST_IDLE;
        wave_len_d = offset;
        done_d     = !abort;
      end
      default: begin
        state_d   = ST_IDLE;
        s_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      wave_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      wave_len_q  <= wave_len_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign wave_len  = wave_len_q;

endmodule

// File: tb/tb_wave_writer.sv
// Scoreboard bench for wave_writer: a capture-level reference model predicts the
// write contents, write timing and done/wave_len; a monitor checks what the DUT presents.
module tb_wave_writer;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort;
  logic [AW-1:0] beg_addr;
  logic [OW:0]   max_len;
  logic [DW-1:0] s_data;
  logic          s_valid, s_last, s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy, done;
  logic [OW:0]   wave_len;

  always #5 clk = ~clk;

  wave_writer #(.ADDR_W(AW), .DATA_W(DW), .OFF_W(OW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .beg_addr  (beg_addr),
    .max_len   (max_len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .wave_len  (wave_len)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t         wr_q[$];   // expected write contents in order
  int unsigned wt_q[$];   // expected cycle of each write
  int unsigned dl_q[$];   // expected wave_len at done
  int unsigned dc_q[$];   // expected cycle of done

  int unsigned cyc_n = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic flag(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a done pulse.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n) begin
      if (mem_we) begin
        if (wr_q.size() == 0) flag("unexpected_write", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", mem_addr, e.a);
          chk("wr_data", mem_wdata, e.d);
        end
        if (wt_q.size() == 0) flag("unexpected_write_timing", 1, 0);
        else chk("wr_cycle", cyc_n, wt_q.pop_front());
      end
      if (done) begin
        if (dl_q.size() == 0) flag("unexpected_done", 1, 0);
        else begin
          chk("done_wave_len", wave_len, dl_q.pop_front());
          chk("done_cycle", cyc_n, dc_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(output bit acc, output int unsigned c);
    @(negedge clk);
    acc = s_valid && s_ready;
    c   = cyc_n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    bit acc;
    int unsigned c;
    for (int unsigned k = 0; k < n; k++) cyc(acc, c);
  endtask

  // One capture: model computes the stored sample count and the write image up front.
  task automatic run_capture(input logic [AW-1:0] beg, input int unsigned mlen,
                             input int unsigned last_at, input int unsigned vmode,
                             input int unsigned abort_after, input bit seq_data,
                             input bit poke_start);
    int unsigned   lim, n, i, guard, c, last_c;
    bit            acc, poked;
    logic [DW-1:0] smp[$];
    wr_t           e;
    lim = (mlen > (1 << OW)) ? (1 << OW) : mlen;
    n = lim;
    if (last_at != 0 && last_at < n) n = last_at;
    if (abort_after != 0 && abort_after < n) n = abort_after;
    for (int unsigned k = 0; k < n; k++) begin
      smp.push_back(seq_data ? DW'(k + 1) : DW'($urandom));
      e.a = beg + AW'(k);
      e.d = smp[k];
      wr_q.push_back(e);
    end

    beg_addr = beg;
    max_len  = (OW+1)'(mlen);
    start    = 1'b1;
    cyc(acc, c);
    start  = 1'b0;
    last_c = c;
    chk("busy_after_start", busy, 1);

    i = 0;
    guard = 0;
    poked = 1'b0;
    while (i < n && guard < 5000) begin
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = (guard % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = smp[i];
      if (s_valid) s_last = (last_at != 0 && i + 1 == last_at);
      else         s_last = 1'($urandom_range(0, 1));
      if (poke_start && i == 1 && !poked) begin
        start    = 1'b1;
        beg_addr = ~beg;
        max_len  = (OW+1)'(1);
        poked    = 1'b1;
      end
      cyc(acc, c);
      start = 1'b0;
      if (acc) begin
        wt_q.push_back(c + 1);
        i++;
        last_c = c;
      end
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (i < n) flag("accept_timeout", i, n);

    if (abort_after != 0) begin
      abort = 1'b1;
      cyc(acc, c);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_ready", s_ready, 0);
      chk("abort_wave_len", wave_len, n);
    end else begin
      dl_q.push_back(n);
      dc_q.push_back(last_c + 2);
      chk("ready_low_after_last", s_ready, 0);
    end

    idle(5);
    chk("writes_pending", wr_q.size(), 0);
    chk("write_times_pending", wt_q.size(), 0);
    chk("done_pending", dl_q.size(), 0);
    chk("idle_busy", busy, 0);
    chk("wave_len_held", wave_len, n);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned mlen, last_at, vmode, ab;
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    beg_addr = '0;
    max_len  = '0;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wave_len", wave_len, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_capture(16'h0100, 4,    0, 0, 0, 1'b1, 1'b0);
    run_capture(16'h2000, 8,    3, 0, 0, 1'b0, 1'b0);
    run_capture(16'hFFFE, 4,    0, 0, 0, 1'b0, 1'b0);
    run_capture(16'h0300, 5,    0, 1, 0, 1'b0, 1'b0);
    run_capture(16'h0400, 6,    0, 0, 2, 1'b0, 1'b1);
    run_capture(16'h0500, 0,    0, 0, 0, 1'b0, 1'b0);
    run_capture(16'hFF00, 1025, 0, 0, 0, 1'b0, 1'b0);

    start    = 1'b1;
    abort    = 1'b1;
    max_len  = (OW+1)'(3);
    beg_addr = 16'h0700;
    idle(1);
    start = 1'b0;
    abort = 1'b0;
    chk("start_with_abort_ignored", busy, 0);
    idle(3);
    chk("start_with_abort_no_write", wr_q.size(), 0);

    for (int r = 0; r < 10; r++) begin
      mlen    = $urandom_range(0, 24);
      last_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 24) : 0;
      vmode   = $urandom_range(0, 2);
      ab      = 0;
      if (mlen > 3 && $urandom_range(0, 3) == 0) begin
        ab      = $urandom_range(1, mlen - 1);
        last_at = 0;
      end
      run_capture(AW'($urandom), mlen, last_at, vmode, ab, 1'b0, r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
